// File: rtl/regfile_pkg.sv
// Shared types and parameter defaults for the register file and its clear sequencer.
// Holds the sequencer state encoding so both modules agree on it.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam bit DEF_ZERO_REG0  = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks an index over every register, one per cycle, while busy.
// Reset lands in CLEAR at index 0; busy is held low while reset itself is asserted.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  signal_clear,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sweep_idx
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  busy_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (signal_clear) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        busy_c = 1'b1;
        // Natural wrap of the index brings it back to 0 as the sweep finishes.
        idx_d  = idx_q + ADDR_WIDTH'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign busy      = busy_c & ~reset;
  assign sweep_idx = idx_q;

endmodule

// File: rtl/register_file_gen.sv
// Two-read, one-write register file with registered reads, write-through bypass,
// optional hard-zero register 0, and a sweep that zeroes the array after reset or on request.
module register_file_gen
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit ZERO_REG0  = DEF_ZERO_REG0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  signal_regwrite,
  input  logic                  signal_clear,
  output logic [DATA_WIDTH-1:0] output_reg1,
  output logic [DATA_WIDTH-1:0] output_reg2,
  output logic                  busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [ADDR_WIDTH-1:0] sweep_idx;
  logic                  user_we;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd1_d, rd2_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q;

  regfile_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clock        (clock),
    .reset        (reset),
    .signal_clear (signal_clear),
    .busy         (busy),
    .sweep_idx    (sweep_idx)
  );

  // A clear request in the same cycle beats the user write.
  assign user_we = signal_regwrite && !signal_clear && !busy && !reset &&
                   !(ZERO_REG0 && (write_reg == '0));

  assign wr_en   = busy || user_we;
  assign wr_addr = busy ? sweep_idx : write_reg;
  assign wr_data = busy ? '0 : write_data;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd1_d = mem[read_reg1];
    rd2_d = mem[read_reg2];
    if (user_we && (read_reg1 == write_reg)) rd1_d = write_data;
    if (user_we && (read_reg2 == write_reg)) rd2_d = write_data;
    if (ZERO_REG0 && (read_reg1 == '0)) rd1_d = '0;
    if (ZERO_REG0 && (read_reg2 == '0)) rd2_d = '0;
  end

  // Forcing zero through the sweep keeps stale contents out of the first idle read.
  always_ff @(posedge clock) begin
    if (reset || busy) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign output_reg1 = busy ? '0 : rd1_q;
  assign output_reg2 = busy ? '0 : rd2_q;

endmodule

// File: tb/tb_register_file_gen.sv
// Bench for register_file_gen: default, ZERO_REG0=1 and ADDR_WIDTH=3 instances
// checked against an array-plus-countdown reference model.
module tb_register_file_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [1:0] rr1, rr2, wr;
  logic [7:0] wd;
  logic       we, clr;
  logic [2:0] w_rr1, w_rr2, w_wr;
  logic [7:0] w_wd;
  logic       w_we, w_clr;

  logic [7:0] a_o1, a_o2, z_o1, z_o2, w_o1, w_o2;
  logic       a_busy, z_busy, w_busy;

  register_file_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG0(1'b0)) dut_a (
    .clock(clock), .reset(reset), .read_reg1(rr1), .read_reg2(rr2),
    .write_reg(wr), .write_data(wd), .signal_regwrite(we), .signal_clear(clr),
    .output_reg1(a_o1), .output_reg2(a_o2), .busy(a_busy));

  register_file_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG0(1'b1)) dut_z (
    .clock(clock), .reset(reset), .read_reg1(rr1), .read_reg2(rr2),
    .write_reg(wr), .write_data(wd), .signal_regwrite(we), .signal_clear(clr),
    .output_reg1(z_o1), .output_reg2(z_o2), .busy(z_busy));

  register_file_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG0(1'b0)) dut_w (
    .clock(clock), .reset(reset), .read_reg1(w_rr1), .read_reg2(w_rr2),
    .write_reg(w_wr), .write_data(w_wd), .signal_regwrite(w_we), .signal_clear(w_clr),
    .output_reg1(w_o1), .output_reg2(w_o2), .busy(w_busy));

  int total = 0;
  int bad   = 0;

  // Reference model: register contents, remaining sweep cycles, last read results.
  logic [7:0] m_regs [3][8];
  int         m_cnt  [3];
  logic [7:0] m_o1   [3];
  logic [7:0] m_o2   [3];
  int         nregs  [3] = '{4, 4, 8};
  bit         zr     [3] = '{1'b0, 1'b1, 1'b0};

  function automatic logic [7:0] m_read(int i, int a);
    return (zr[i] && a == 0) ? 8'h00 : m_regs[i][a];
  endfunction

  function automatic void model_edge(int i, logic rst, int r1, int r2, int wa,
                                     logic [7:0] wdat, logic wen, logic cl);
    if (rst) begin
      m_cnt[i] = nregs[i];
      m_o1[i]  = 8'h00;
      m_o2[i]  = 8'h00;
    end else if (m_cnt[i] > 0) begin
      m_regs[i][nregs[i] - m_cnt[i]] = 8'h00;
      m_cnt[i] = m_cnt[i] - 1;
      m_o1[i]  = 8'h00;
      m_o2[i]  = 8'h00;
    end else begin
      if (cl) m_cnt[i] = nregs[i];
      else if (wen && !(zr[i] && wa == 0)) m_regs[i][wa] = wdat;
      m_o1[i] = m_read(i, r1);
      m_o2[i] = m_read(i, r2);
    end
  endfunction

  function automatic logic [16:0] expv(int i);
    if (!reset && m_cnt[i] > 0) return {1'b1, 16'h0000};
    return {1'b0, m_o1[i], m_o2[i]};
  endfunction

  function automatic logic [16:0] obs(int i);
    case (i)
      0:       return {a_busy, a_o1, a_o2};
      1:       return {z_busy, z_o1, z_o2};
      default: return {w_busy, w_o1, w_o2};
    endcase
  endfunction

  task automatic step();
    model_edge(0, reset, int'(rr1), int'(rr2), int'(wr), wd, we, clr);
    model_edge(1, reset, int'(rr1), int'(rr2), int'(wr), wd, we, clr);
    model_edge(2, reset, int'(w_rr1), int'(w_rr2), int'(w_wr), w_wd, w_we, w_clr);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    we = 1'b0; clr = 1'b0; w_we = 1'b0; w_clr = 1'b0;
  endtask

  task automatic test_reset();
    int cntb [3] = '{0, 0, 0};
    reset = 1'b1;
    idle_inputs();
    rr1 = 2'd0; rr2 = 2'd0; wr = 2'd0; wd = 8'h00;
    w_rr1 = 3'd0; w_rr2 = 3'd0; w_wr = 3'd0; w_wd = 8'h00;
    step();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs(i) !== 17'h0) begin
        bad++; $display("FAIL reset_state inst=%0d got=%h want=%h", i, obs(i), 17'h0);
      end
    end
    reset = 1'b0;
    #1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (obs(i)[16]) cntb[i]++;
        total++;
        if (obs(i) !== expv(i)) begin
          bad++; $display("FAIL reset_sweep inst=%0d cyc=%0d got=%h want=%h", i, c, obs(i), expv(i));
        end
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cntb[i] != nregs[i]) begin
        bad++; $display("FAIL reset_busy_len inst=%0d got=%0d want=%0d", i, cntb[i], nregs[i]);
      end
    end
    for (int a = 0; a < 8; a++) begin
      rr1 = 2'(a); rr2 = 2'(3 - a); w_rr1 = 3'(a); w_rr2 = 3'(7 - a);
      step();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== 17'h0) begin
          bad++; $display("FAIL reset_readback inst=%0d addr=%0d got=%h want=%h", i, a, obs(i), 17'h0);
        end
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; wr = 2'd2; wd = 8'hA5;
    w_we = 1'b1; w_wr = 3'd2; w_wd = 8'hA5;
    step();
    idle_inputs();
    rr1 = 2'd2; rr2 = 2'd0; w_rr1 = 3'd2; w_rr2 = 3'd0;
    step();
    total++;
    if (a_o1 !== 8'hA5) begin bad++; $display("FAIL write_read_a got=%h want=%h", a_o1, 8'hA5); end
    total++;
    if (z_o1 !== 8'hA5) begin bad++; $display("FAIL write_read_z got=%h want=%h", z_o1, 8'hA5); end
    total++;
    if (w_o1 !== 8'hA5) begin bad++; $display("FAIL write_read_w got=%h want=%h", w_o1, 8'hA5); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wr = 2'd1; wd = 8'h3C; rr1 = 2'd1; rr2 = 2'd1;
    step();
    we = 1'b0;
    total++;
    if ({a_o1, a_o2} !== {8'h3C, 8'h3C}) begin
      bad++; $display("FAIL bypass_a got=%h want=%h", {a_o1, a_o2}, 16'h3C3C);
    end
    total++;
    if ({z_o1, z_o2} !== {8'h3C, 8'h3C}) begin
      bad++; $display("FAIL bypass_z got=%h want=%h", {z_o1, z_o2}, 16'h3C3C);
    end
    rr1 = 2'd1; rr2 = 2'd2;
    step();
    total++;
    if ({a_o1, a_o2} !== {8'h3C, 8'hA5}) begin
      bad++; $display("FAIL bypass_persist got=%h want=%h", {a_o1, a_o2}, 16'h3CA5);
    end
  endtask

  task automatic test_clear_priority();
    int busy_cycles = 0;
    for (int r = 0; r < 4; r++) begin
      we = 1'b1; wr = 2'(r); wd = 8'(8'h11 * (r + 1));
      step();
    end
    clr = 1'b1; we = 1'b1; wr = 2'd3; wd = 8'hFF; rr1 = 2'd3; rr2 = 2'd3;
    step();
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      if (a_busy) busy_cycles++;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== expv(i)) begin
          bad++; $display("FAIL clear_sweep inst=%0d cyc=%0d got=%h want=%h", i, c, obs(i), expv(i));
        end
      end
      if (a_busy) begin
        we = 1'($urandom); clr = 1'($urandom); wd = 8'($urandom);
        wr = 2'($urandom); rr1 = 2'($urandom); rr2 = 2'($urandom);
      end else begin
        idle_inputs();
      end
      step();
    end
    idle_inputs();
    total++;
    if (busy_cycles != 4) begin
      bad++; $display("FAIL clear_busy_len got=%0d want=%0d", busy_cycles, 4);
    end
    for (int a = 0; a < 4; a++) begin
      rr1 = 2'(a); rr2 = 2'(a);
      step();
      total++;
      if ({a_o1, a_o2, z_o1, z_o2} !== 32'h0) begin
        bad++; $display("FAIL clear_readback addr=%0d got=%h want=%h", a, {a_o1, a_o2, z_o1, z_o2}, 32'h0);
      end
    end
  endtask

  task automatic test_zero_reg0();
    we = 1'b1; wr = 2'd0; wd = 8'h77; rr1 = 2'd0; rr2 = 2'd0;
    step();
    we = 1'b0;
    total++;
    if ({z_o1, z_o2} !== 16'h0000) begin
      bad++; $display("FAIL zero_reg0_bypass got=%h want=%h", {z_o1, z_o2}, 16'h0000);
    end
    total++;
    if (a_o1 !== 8'h77) begin bad++; $display("FAIL reg0_bypass_a got=%h want=%h", a_o1, 8'h77); end
    step();
    total++;
    if (z_o1 !== 8'h00) begin bad++; $display("FAIL zero_reg0_read got=%h want=%h", z_o1, 8'h00); end
    total++;
    if (a_o1 !== 8'h77) begin bad++; $display("FAIL reg0_read_a got=%h want=%h", a_o1, 8'h77); end
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cycles = 0;
    for (int r = 0; r < 8; r++) begin
      w_we = 1'b1; w_wr = 3'(r); w_wd = 8'($urandom) | 8'h01;
      step();
    end
    idle_inputs();
    w_clr = 1'b1;
    step();
    w_clr = 1'b0;
    step();
    step();
    total++;
    if (w_busy !== 1'b1) begin bad++; $display("FAIL mid_sweep_busy got=%b want=%b", w_busy, 1'b1); end
    reset = 1'b1;
    step();
    total++;
    if (obs(2) !== 17'h0) begin bad++; $display("FAIL mid_reset_state got=%h want=%h", obs(2), 17'h0); end
    reset = 1'b0;
    #1;
    for (int c = 0; c < 14; c++) begin
      if (w_busy) busy_cycles++;
      total++;
      if (obs(2) !== expv(2)) begin
        bad++; $display("FAIL mid_sweep cyc=%0d got=%h want=%h", c, obs(2), expv(2));
      end
      step();
    end
    total++;
    if (busy_cycles != 8) begin
      bad++; $display("FAIL mid_busy_len got=%0d want=%0d", busy_cycles, 8);
    end
    for (int a = 0; a < 8; a++) begin
      w_rr1 = 3'(a); w_rr2 = 3'(a);
      step();
      total++;
      if ({w_o1, w_o2} !== 16'h0000) begin
        bad++; $display("FAIL mid_readback addr=%0d got=%h want=%h", a, {w_o1, w_o2}, 16'h0000);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      rr1 = 2'($urandom); rr2 = 2'($urandom); wr = 2'($urandom); wd = 8'($urandom);
      we = 1'($urandom); clr = ($urandom_range(0, 15) == 0);
      w_rr1 = 3'($urandom); w_rr2 = 3'($urandom); w_wr = 3'($urandom); w_wd = 8'($urandom);
      w_we = 1'($urandom); w_clr = ($urandom_range(0, 15) == 0);
      step();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs(i) !== expv(i)) begin
          bad++; $display("FAIL random inst=%0d cyc=%0d got=%h want=%h", i, c, obs(i), expv(i));
        end
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_o1[i] = 8'h00; m_o2[i] = 8'h00;
      for (int a = 0; a < 8; a++) m_regs[i][a] = 8'h00;
    end
    test_reset();
    test_write_read();
    test_bypass();
    test_clear_priority();
    test_zero_reg0();
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
